// File: rtl/sprite_scan_reader.sv
// Sprite scan reader: per-pixel hit test against the live sprite slots,
// RAM read address generation and a two-stage pixel/sync pipeline.
// Shadow slot registers commit to the live set only on frame_start.
module sprite_scan_reader #(
  parameter int unsigned NSLOTS   = 4,
  parameter logic [3:0]  BG_COLOR = 4'h0,
  parameter logic [3:0]  TRANSP   = 4'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        active,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        frame_start,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_slot,
  input  logic        cfg_en,
  input  logic [2:0]  cfg_id,
  input  logic [9:0]  cfg_x,
  input  logic [9:0]  cfg_y,
  output logic [14:0] addr_out,
  input  logic [3:0]  q,
  output logic [3:0]  pixel,
  output logic        pixel_valid,
  output logic        hsync_out,
  output logic        vsync_out
);

  logic       r_sh_en [NSLOTS];
  logic [2:0] r_sh_id [NSLOTS];
  logic [9:0] r_sh_x  [NSLOTS];
  logic [9:0] r_sh_y  [NSLOTS];

  logic       r_lv_en [NSLOTS];
  logic [2:0] r_lv_id [NSLOTS];
  logic [9:0] r_lv_x  [NSLOTS];
  logic [9:0] r_lv_y  [NSLOTS];

  logic        w_any;
  logic [14:0] w_addr;
  logic [10:0] w_dx;
  logic [10:0] w_dy;

  logic [14:0] r_addr;
  logic        r_hit1;
  logic        r_act1;
  logic        r_hs1;
  logic        r_vs1;

  logic [3:0]  r_pixel;
  logic        r_act2;
  logic        r_hs2;
  logic        r_vs2;

  // Shadow slot registers, written by the config path
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NSLOTS; i++) begin
        r_sh_en[i] <= 1'b0;
        r_sh_id[i] <= '0;
        r_sh_x[i]  <= '0;
        r_sh_y[i]  <= '0;
      end
    end else if (cfg_we) begin
      r_sh_en[cfg_slot] <= cfg_en;
      r_sh_id[cfg_slot] <= cfg_id;
      r_sh_x[cfg_slot]  <= cfg_x;
      r_sh_y[cfg_slot]  <= cfg_y;
    end
  end

  // Live slot registers: commit the pre-write shadow set at frame start
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NSLOTS; i++) begin
        r_lv_en[i] <= 1'b0;
        r_lv_id[i] <= '0;
        r_lv_x[i]  <= '0;
        r_lv_y[i]  <= '0;
      end
    end else if (frame_start) begin
      for (int unsigned i = 0; i < NSLOTS; i++) begin
        r_lv_en[i] <= r_sh_en[i];
        r_lv_id[i] <= r_sh_id[i];
        r_lv_x[i]  <= r_sh_x[i];
        r_lv_y[i]  <= r_sh_y[i];
      end
    end
  end

  // Stage 0 hit test: ascending scan, first hit wins so the lowest index has priority.
  // A negative difference sets bit 10, so only 0..63 offsets qualify.
  always_comb begin
    w_any  = 1'b0;
    w_addr = '0;
    w_dx   = '0;
    w_dy   = '0;
    for (int unsigned i = 0; i < NSLOTS; i++) begin
      w_dx = {1'b0, hcount} - {1'b0, r_lv_x[i]};
      w_dy = {1'b0, vcount} - {1'b0, r_lv_y[i]};
      if (!w_any && r_lv_en[i] && active &&
          (w_dx[10:6] == '0) && (w_dy[10:6] == '0)) begin
        w_any  = 1'b1;
        w_addr = {r_lv_id[i], w_dy[5:0], w_dx[5:0]};
      end
    end
  end

  // Stage 1: RAM address (held when nothing hits) and aligned control bits
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr <= '0;
      r_hit1 <= 1'b0;
      r_act1 <= 1'b0;
      r_hs1  <= 1'b0;
      r_vs1  <= 1'b0;
    end else begin
      if (w_any) r_addr <= w_addr;
      r_hit1 <= w_any;
      r_act1 <= active;
      r_hs1  <= hsync_in;
      r_vs1  <= vsync_in;
    end
  end

  // Stage 2: colour select using the negedge RAM data, syncs delayed to match
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pixel <= BG_COLOR;
      r_act2  <= 1'b0;
      r_hs2   <= 1'b0;
      r_vs2   <= 1'b0;
    end else begin
      r_pixel <= (r_act1 && r_hit1 && (q != TRANSP)) ? q : BG_COLOR;
      r_act2  <= r_act1;
      r_hs2   <= r_hs1;
      r_vs2   <= r_vs1;
    end
  end

  assign addr_out    = r_addr;
  assign pixel       = r_pixel;
  assign pixel_valid = r_act2;
  assign hsync_out   = r_hs2;
  assign vsync_out   = r_vs2;

endmodule

// File: doc/sprite_scan_reader.md
Name: sprite_scan_reader

Overview:
- Read-side engine for the 32768x4 sprite RAM, which holds 8 sprites of 64x64 pixels at 4 bits each. Address is {sprite_id[2:0], row[5:0], col[5:0]}.
- Takes the VGA timing generator's hcount/vcount and decides which on-screen sprite slot covers the current pixel. It drives the RAM read address and returns the 4-bit pixel colour, with syncs delayed to match.
- Slot placement is written by the SPI/config logic into shadow registers. Shadow registers commit to the live set only at frame start, so a frame never tears.

Parameters:
- NSLOTS, 4, number of on-screen sprite slots; slot index width is 2 bits.
- BG_COLOR, 4'h0, colour output where no opaque sprite pixel covers the position.
- TRANSP, 4'h0, sprite pixel value treated as transparent.

Ports:
- clk  in  1  pixel clock; also drives the RAM read clock (RAM samples address on the negedge).
- reset_n  in  1  synchronous active-low reset.
- hcount  in  10  current pixel x.
- vcount  in  10  current pixel y.
- active  in  1  visible-area flag.
- hsync_in  in  1  horizontal sync from the timing generator.
- vsync_in  in  1  vertical sync from the timing generator.
- frame_start  in  1  one-cycle pulse at the first cycle of vertical blank.
- cfg_we  in  1  shadow slot write strobe.
- cfg_slot  in  2  slot to write.
- cfg_en  in  1  slot enable.
- cfg_id  in  3  sprite index.
- cfg_x  in  10  slot left edge.
- cfg_y  in  10  slot top edge.
- addr_out  out  15  RAM read address.
- q  in  4  RAM read data.
- pixel  out  4  final colour.
- pixel_valid  out  1  active, delayed to align with pixel.
- hsync_out  out  1  hsync_in, delayed to align with pixel.
- vsync_out  out  1  vsync_in, delayed to align with pixel.

Behaviour:
- Reset (reset_n=0 at posedge clk):
  - All shadow and live slots cleared: en=0, id=0, x=0, y=0.
  - addr_out=0, pixel=BG_COLOR, pixel_valid=0, hsync_out=0, vsync_out=0, pipeline hit flags=0.
  - Reset mid-frame discards in-flight pixels; outputs restart from reset values on the next cycle.
- Config path:
  - cfg_we=1 writes {en,id,x,y} into shadow[cfg_slot] on that clock edge.
  - frame_start=1 copies all shadow slots into live slots.
  - If cfg_we and frame_start are high on the same edge, live receives the pre-write shadow value. The new write lands in shadow and takes effect at the next frame_start.
- Hit test (stage 0, combinational on inputs):
  - Per live slot: dx = {1'b0,hcount} - {1'b0,x}, dy = {1'b0,vcount} - {1'b0,y}, both 11-bit.
  - hit_i = en & active & (dx[10:6]==0) & (dy[10:6]==0). A negative difference sets bit 10, so no hit.
  - Covers x..x+63 inclusive. Slots placed past 1023-63 are clipped by the hcount range; there is no wrap.
  - Priority: the lowest-index hitting slot wins.
- Stage 1 (posedge N+1):
  - addr_out <= {id_win, dy[5:0], dx[5:0]} if any hit; otherwise addr_out holds its previous value.
  - hit1 <= any hit. active, hsync_in and vsync_in are registered alongside.
- RAM returns q on the negedge within cycle N+1.
- Stage 2 (posedge N+2):
  - pixel <= (hit1 && q!=TRANSP) ? q : BG_COLOR.
  - pixel_valid, hsync_out and vsync_out <= their stage-1 copies.
  - pixel is forced to BG_COLOR when the delayed active is 0.
- Latency: exactly 2 clk cycles from hcount/vcount to pixel, with syncs matched. Throughput is 1 pixel per clock with no stalls.
- Transparency does not fall through to lower-priority slots. Only one RAM read per pixel is possible, so a transparent top pixel shows BG_COLOR.
- Two slots may reference the same sprite id; this is legal.

Test Plan:
- Reset with reset_n=0 for 3 cycles, then release with no config writes; sweep a full frame -> pixel=BG_COLOR throughout, pixel_valid tracks active delayed by 2, and addr_out stays 0.
- Write slot0 {en=1,id=3,x=100,y=50}, then pulse frame_start; drive hcount=100, vcount=50 -> addr_out=15'h3000 after 1 cycle, and with q=4'hA, pixel=4'hA after 2 cycles. Drive hcount=163, vcount=113 -> addr_out=15'h3FFF. hcount=164 -> pixel=BG_COLOR.
- Overlap: slot0 {id=1,x=0,y=0} and slot2 {id=5,x=0,y=0}, both enabled; pixel at (10,10) -> addr_out uses id=1 (15'h128A). Disable slot0 via shadow write plus frame_start -> addr_out=15'h528A.
- Write slot1 x=200 mid-frame without frame_start -> output unchanged. Issue cfg_we and frame_start on the same edge -> old value is live that frame and the new value is live after the next frame_start.
- Transparency: enabled slot with RAM model returning q=TRANSP -> pixel=BG_COLOR. With q=4'h7 -> pixel=4'h7. Same scenario with active=0 -> pixel=BG_COLOR.
- Boundary: slot x=1000, y=0; sweep hcount 999..1023 -> hit only for hcount>=1000 with col=hcount-1000, and no hit at hcount=0..35 (no wrap). Assert reset_n=0 mid-line -> next-cycle outputs equal reset values.
